// File: rtl/z80_sys_pkg.sv
// Shared Z80 system types and constants.
// VRAM arbiter state encoding and memory map bases.
package z80_sys_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VID,
    CPU
  } arb_state_t;

  localparam int          VRAM_AW   = 11;
  localparam logic [15:0] OBJ_BASE  = 16'h7000;
  localparam logic [15:0] TILE_BASE = 16'h7400;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between Z80 CPU and video fetch.
// Define VRAM_ARB_STARVE_EN to bound CPU starvation by STARVE_LIMIT.
import z80_sys_pkg::*;

module vram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_memrd,
  input  logic               cpu_memwr,
  input  logic               cpu_obj_ena,
  input  logic               cpu_tile_ena,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               wait_n,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_addr,
  output logic               vid_gnt,
  output logic [7:0]         vid_rdata,
  output logic               vid_rvalid,
  output logic               ram_en,
  output logic               ram_we,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata
);

  arb_state_t state, state_nx;
  logic cpu_pend, cpu_elig;
  logic cpu_done, cpu_inflight;
  logic gnt_vid, gnt_cpu;
  logic rd_q, cpu_fin;
  logic starve;
  logic unused_addr;

  assign unused_addr = ^cpu_addr[15:10];

  assign cpu_pend = (cpu_memrd | cpu_memwr)
                  & (cpu_obj_ena | cpu_tile_ena);
  assign cpu_elig = cpu_pend & ~cpu_done & ~cpu_inflight;

`ifdef VRAM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] streak, streak_nx;

  assign starve = (streak == SW'(STARVE_LIMIT));

  always_comb begin
    streak_nx = streak;
    if (!cpu_elig || gnt_cpu)
      streak_nx = '0;
    else if (gnt_vid && !starve)
      streak_nx = streak + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak <= '0;
    else     streak <= streak_nx;
  end
`else
  localparam int unused_limit = STARVE_LIMIT;
  assign starve = 1'b0;
`endif

  always_comb begin
    gnt_vid  = 1'b0;
    gnt_cpu  = 1'b0;
    state_nx = IDLE;
    if (cpu_elig && (!vid_req || starve)) begin
      gnt_cpu  = 1'b1;
      state_nx = CPU;
    end else if (vid_req) begin
      gnt_vid  = 1'b1;
      state_nx = VID;
    end
  end

  // state holds last cycle's grant, i.e. the access now on the RAM port
  assign cpu_fin = ((state == CPU) & ram_we) | rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      vid_rvalid   <= 1'b0;
      rd_q         <= 1'b0;
      cpu_rdata    <= '0;
      cpu_done     <= 1'b0;
      cpu_inflight <= 1'b0;
    end else begin
      state      <= state_nx;
      ram_en     <= gnt_vid | gnt_cpu;
      ram_we     <= gnt_cpu & cpu_memwr;
      if (gnt_cpu) begin
        ram_addr  <= {cpu_tile_ena, cpu_addr[9:0]};
        ram_wdata <= cpu_wdata;
      end else if (gnt_vid) begin
        ram_addr  <= vid_addr;
      end
      vid_rvalid <= (state == VID);
      rd_q       <= (state == CPU) & ~ram_we;
      if (rd_q)
        cpu_rdata <= ram_rdata;
      if (gnt_cpu)
        cpu_inflight <= 1'b1;
      else if (cpu_fin)
        cpu_inflight <= 1'b0;
      if (cpu_fin)
        cpu_done <= 1'b1;
      else if (!cpu_pend)
        cpu_done <= 1'b0;
    end
  end

  assign vid_gnt   = gnt_vid & ~rst;
  assign vid_rdata = vid_rvalid ? ram_rdata : 8'h00;
  assign wait_n    = rst | ~(cpu_pend & ~cpu_done);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural VRAM.
// Honours VRAM_ARB_STARVE_EN for the starvation expectations.
module tb_vram_arbiter;

  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_memrd = 1'b0, cpu_memwr = 1'b0;
  logic        cpu_obj_ena = 1'b0, cpu_tile_ena = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        wait_n;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic        vid_gnt;
  logic [7:0]  vid_rdata;
  logic        vid_rvalid;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  logic        vid_on = 1'b0;
  logic        r_req = 1'b0, d_req = 1'b0;
  logic [10:0] r_addr = '0, d_addr = '0;

  assign vid_req  = vid_on ? r_req  : d_req;
  assign vid_addr = vid_on ? r_addr : d_addr;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [7:0] last_rd = '0;

  logic [7:0]  ram_mem   [2048];
  logic [7:0]  model_mem [2048];
  logic [7:0]  vq [$];
  logic [7:0]  rq [$];
  logic [18:0] wq [$];
  bit          rd_chk = 0;

  vram_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_memrd(cpu_memrd), .cpu_memwr(cpu_memwr),
    .cpu_obj_ena(cpu_obj_ena), .cpu_tile_ena(cpu_tile_ena),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .wait_n(wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [18:0] w;
    logic        pend;
    if (rst) begin
      vq.delete(); rq.delete(); wq.delete();
      rd_chk = 0;
    end else begin
      if (vid_rvalid) begin
        if (vq.size() == 0) chk("vid_extra", 1, 0);
        else chk("vid_rdata", vid_rdata, vq.pop_front());
      end
      if (vid_req && vid_gnt)
        vq.push_back(model_mem[vid_addr]);
      if (ram_en && ram_we) begin
        wr_count++;
        if (wq.size() == 0) chk("wr_extra", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr_data", {ram_addr, ram_wdata}, w);
        end
      end
      pend = (cpu_memrd | cpu_memwr) & (cpu_obj_ena | cpu_tile_ena);
      if (!pend)
        rd_chk = 0;
      else if (cpu_memrd && wait_n && !rd_chk) begin
        rd_chk = 1;
        if (rq.size() == 0) chk("rd_extra", 1, 0);
        else chk("cpu_rdata", cpu_rdata, rq.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    r_req  = ($urandom % 3) != 0;
    r_addr = {1'b0, 10'($urandom)};
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drop();
    cpu_memrd = 0; cpu_memwr = 0;
    cpu_obj_ena = 0; cpu_tile_ena = 0;
  endtask

  task automatic issue(input bit wr, input bit tile,
                       input logic [9:0] a, input logic [7:0] d);
    logic [10:0] ra;
    ra = {tile, a};
    cpu_addr     = (tile ? 16'h7400 : 16'h7000) | {6'b0, a};
    cpu_memrd    = !wr;
    cpu_memwr    = wr;
    cpu_obj_ena  = !tile;
    cpu_tile_ena = tile;
    cpu_wdata    = d;
    if (wr) begin
      wq.push_back({ra, d});
      model_mem[ra] = d;
    end else begin
      rq.push_back(model_mem[ra]);
      last_rd = model_mem[ra];
    end
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!wait_n && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_release", wait_n, 1);
  endtask

  task automatic cpu_op(input bit wr, input bit tile,
                        input logic [9:0] a, input logic [7:0] d,
                        input int hold);
    tick();
    issue(wr, tile, a, d);
    wait_rdy();
    repeat (hold) @(negedge clk);
    tick();
    drop();
  endtask

  initial begin : stim
    int n, bad, w0;
    bit stop;
    logic [15:0] pat;
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i]   = 8'($urandom);
      model_mem[i] = ram_mem[i];
    end
    #1 rst = 1;
    cpu_memrd = 1; cpu_tile_ena = 1; d_req = 1;
    #2;
    chk("rst_wait_n", wait_n, 1);
    chk("rst_vid_gnt", vid_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    drop(); d_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (2) tick();

    // directed CPU read of 0x7405
    tick();
    issue(0, 1, 10'h005, 8'h00);
    @(negedge clk) chk("rd_wait_n_N", wait_n, 0);
    @(negedge clk);
    chk("rd_ram_rd", {ram_en, ram_we}, 2'b10);
    chk("rd_ram_addr", ram_addr, 11'h405);
    @(negedge clk) chk("rd_wait_n_N2", wait_n, 0);
    @(negedge clk) chk("rd_wait_n_N3", wait_n, 1);
    tick(); drop();
    repeat (2) tick();

    // directed CPU write 0xA5 to 0x7010, held 5 cycles
    w0 = wr_count;
    tick();
    issue(1, 0, 10'h010, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("wr_ram_we", {ram_en, ram_we}, 2'b11);
    chk("wr_ram_addr", ram_addr, 11'h010);
    chk("wr_ram_wdata", ram_wdata, 8'hA5);
    @(negedge clk) chk("wr_wait_n", wait_n, 1);
    repeat (2) @(negedge clk);
    tick(); drop();
    @(negedge clk) chk("wr_once", wr_count - w0, 1);
    chk("rdata_hold", cpu_rdata, last_rd);
    repeat (2) tick();

    // video burst 0..7
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      d_req  = (k < 8);
      d_addr = 11'(k);
      @(negedge clk) pat[k] = vid_rvalid;
    end
    chk("vid_burst_pattern", pat, 16'h03FC);
    d_req = 0;

    // randomized traffic
    vid_on = 1;
    for (int i = 0; i < 40; i++) begin
      bit wr, tile;
      wr   = 1'($urandom);
      tile = wr ? 1'b1 : 1'($urandom);
      cpu_op(wr, tile, 10'($urandom), 8'($urandom),
             int'($urandom % 3));
      repeat ($urandom_range(0, 2)) tick();
    end
    vid_on = 0;
    repeat (4) tick();

    // out-of-region strobe
    tick();
    cpu_addr = 16'h7800; cpu_memrd = 1;
    bad = 0;
    repeat (4) @(negedge clk) if (!wait_n || ram_en) bad++;
    chk("out_of_region", bad, 0);
    tick(); drop();
    repeat (2) tick();

    // reset during N+1 of a CPU read
    tick();
    issue(0, 1, 10'h012, 8'h00);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("rst_mid_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    chk("rst_mid_vid", {vid_rvalid, vid_rdata, vid_gnt}, 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    chk("rst_mid_wait_n", wait_n, 1);
    drop();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    bad = 0;
    repeat (6) @(negedge clk)
      if (ram_en || vid_rvalid || !wait_n) bad++;
    chk("rst_discard", bad, 0);

    // video held high plus CPU read
    tick();
    d_req = 1; d_addr = 11'h020;
    repeat (2) tick();
    issue(0, 1, 10'h033, 8'h00);
    n = 0; stop = 0;
    for (int i = 0; i < 20 && !stop; i++) begin
      @(negedge clk);
      if (vid_gnt) n++;
      else stop = 1;
    end
`ifdef VRAM_ARB_STARVE_EN
    chk("starve_vid_grants", n, SL);
    @(negedge clk) chk("starve_vid_resume", vid_gnt, 1);
    wait_rdy();
    tick(); drop(); d_req = 0;
`else
    chk("strict_vid_grants", n, 20);
    chk("strict_cpu_waits", wait_n, 0);
    tick(); d_req = 0;
    wait_rdy();
    tick(); drop();
`endif

    repeat (8) tick();
    chk("vq_empty", vq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive video grants while the CPU waits.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cpu_addr  in  16  Z80 address.
- cpu_memrd / cpu_memwr  in  1 each  decoded memory read/write strobes.
- cpu_obj_ena / cpu_tile_ena  in  1 each  region hits for 0x7000-0x73FF and 0x7400-0x77FF.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered CPU read data.
- wait_n  out  1  Z80 WAIT, active-low.
- vid_req  in  1  video fetch request.
- vid_addr  in  11  video address; bit 10 = tile.
- vid_gnt  out  1  combinational accept; transfer occurs when vid_req & vid_gnt.
- vid_rdata  out  8  video read data.
- vid_rvalid  out  1  vid_rdata valid.
- ram_en, ram_we  out  1 each  VRAM enable and write strobe.
- ram_addr  out  11  VRAM address.
- ram_wdata  out  8  VRAM write data.
- ram_rdata  in  8  VRAM read data; synchronous, 1-cycle latency.

Function
REQ-003 SHALL define cpu_pend = (cpu_memrd | cpu_memwr) & (cpu_obj_ena | cpu_tile_ena).
REQ-004 SHALL map the CPU VRAM address as {cpu_tile_ena, cpu_addr[9:0]}.
REQ-005 SHALL make one grant decision per cycle N. Eligible requesters: video = vid_req; CPU = cpu_pend & ~cpu_done & ~cpu_inflight.
REQ-006 SHALL give video priority, except that the CPU wins when the streak counter equals STARVE_LIMIT.
REQ-007 SHALL operate the streak counter as follows:
- increments on each video grant while the CPU is eligible;
- clears on a CPU grant and whenever the CPU is not eligible;
- saturates at STARVE_LIMIT.
REQ-008 SHALL, for a grant in cycle N, register ram_en, ram_we, ram_addr and ram_wdata so they are presented in cycle N+1. ram_we SHALL be 1 only for a CPU write.
REQ-009 SHALL deassert ram_en in any cycle following a cycle with no grant.
REQ-010 SHALL return video read data with vid_rvalid=1 and vid_rdata=ram_rdata in cycle N+2. Back-to-back video grants SHALL give one datum per cycle.
REQ-011 SHALL set cpu_inflight on a CPU grant and clear it when cpu_done sets.
REQ-012 SHALL set cpu_done at the end of N+1 for a write. For a read, it SHALL set at the end of N+2, and cpu_rdata SHALL be loaded from ram_rdata at that same edge.
REQ-013 SHALL drive wait_n = ~(cpu_pend & ~cpu_done), combinationally.
REQ-014 SHALL clear cpu_done in the first cycle in which cpu_pend=0. One CPU bus cycle SHALL produce exactly one VRAM access.
REQ-015 SHALL use FSM states IDLE (no grant), VID (video granted) and CPU (CPU granted); next state follows REQ-005/REQ-006 every cycle.
REQ-016 SHALL ignore CPU strobes outside the obj/tile regions: wait_n stays 1 and no access is made.
REQ-017 SHALL hold cpu_rdata when no CPU read completes.

Reset
REQ-018 SHALL, while rst=1, force these values regardless of clk:
- state IDLE, streak counter 0, cpu_done 0, cpu_inflight 0;
- ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0;
- vid_rvalid 0, vid_rdata 0, cpu_rdata 0;
- vid_gnt 0, wait_n 1.
REQ-019 SHALL discard any access in flight when rst asserts: no vid_rvalid and no cpu_done for it after release.

Configuration
REQ-020 SHALL compile in starvation protection (REQ-006/REQ-007 counter) only when VRAM_ARB_STARVE_EN is defined.
REQ-021 SHALL, without VRAM_ARB_STARVE_EN, apply strict video priority, contain no counter, and leave STARVE_LIMIT unused.

Structure
REQ-022 SHALL take the state enum (IDLE/VID/CPU), VRAM_AW=11, OBJ_BASE=16'h7000 and TILE_BASE=16'h7400 from shared package z80_sys_pkg.
REQ-023 SHALL be a single module with no sub-modules.

Verification
REQ-024 SHALL cover these directed scenarios:
- CPU read of 0x7405 with video idle -> ram_addr=0x405 in N+1; cpu_rdata=ram_rdata; wait_n high from N+3.
- CPU write 0xA5 to 0x7010 -> ram_we=1, ram_addr=0x010, ram_wdata=0xA5 in N+1; exactly one write even while memwr is held 5 cycles.
- vid_req held 8 cycles, addr 0x000..0x007 -> 8 consecutive vid_rvalid, 2-cycle latency, in order.
- With VRAM_ARB_STARVE_EN and STARVE_LIMIT=4, vid_req held high plus CPU read -> exactly 4 video grants, then the CPU grant, then video resumes.
- Without VRAM_ARB_STARVE_EN, same stimulus -> CPU waits until vid_req drops.
- rst pulsed in N+1 of a CPU read -> all outputs at reset values; wait_n=1; no ram access after release until a new grant.
